csr_stream_feeder: RTL and testbench
====================================

Name: csr_stream_feeder

Overview:
- Host-side transmitter for the sparse MVM accelerator's CSR load protocol.
- Holds a dense 4x4 8-bit weight matrix loaded by a host write port. On go, it compresses the matrix on the fly to CSR: zeros are skipped and each non-zero becomes a (row, column, value) entry.
- Streams the entries, then the 4-bit spike train, over the sending_cpu/done_list/fetch_ready handshake.
- Collects the 4 toggle-signalled results from the accelerator and presents them to the host.

Parameters:
- N_DIM, 4, matrix dimension; fixed at 4, as the row/column fields are 2 bits.
- VAL_W, 8, weight and result width.
- TIMEOUT_CYCLES, 255, maximum wait per handshake event before an error abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mat_wr_en  in  1  host write strobe for the weight matrix
- mat_addr  in  4  write address, row-major {row[1:0], col[1:0]}
- mat_data  in  8  weight value
- spike_in  in  4  spike train, sampled on go
- go  in  1  start one full transaction; ignored unless idle
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at the end of a transaction
- err  out  1  sticky timeout flag; cleared by the next accepted go
- res_valid  out  1  one-cycle pulse per captured result
- res_idx  out  2  result row index
- res_data  out  8  result value
- acc_start  out  1  start pulse to the accelerator
- sending_cpu  out  1  entry/spike-train strobe
- done_list  out  1  end-of-CSR-list strobe
- row_val  out  2  CSR row of the current entry
- column_val  out  2  CSR column of the current entry
- value  out  8  CSR value; in the spike phase, {4'b0, spike}
- fetch_ready  in  1  accelerator ready for the next entry
- sending_out  in  1  accelerator result toggle
- output_val  in  8  accelerator result data

Behaviour:
- Reset values:
  - All outputs are 0.
  - The scan pointer, timeout counter, result counter and sending_out history register are 0.
  - The matrix RAM is not reset; the host must load it.
- Matrix writes:
  - Accepted in any state.
  - A write during a transaction takes effect immediately. The scan uses whatever is stored when the scan pointer reaches that address.
- FSM states: IDLE, START, SCAN, SEND, WAIT_RDY, LIST_END, SPIKE, COLLECT, FINISH.
- IDLE, go=1:
  - Latch spike_in and clear err.
  - Set busy=1.
  - Go to START.
- START:
  - acc_start=1 for exactly 1 cycle.
  - Scan pointer p=0.
  - Go to WAIT_RDY.
- WAIT_RDY:
  - Wait for fetch_ready=1, then go to SCAN.
- SCAN:
  - Examines 1 address per cycle.
  - If mem[p]==0, increment p.
  - If mem[p]!=0, go to SEND.
  - After p=15 with no further non-zero entry, go to LIST_END.
- SEND (1 cycle):
  - sending_cpu=1, row_val=p[3:2], column_val=p[1:0], value=mem[p].
  - If p==15, go to LIST_END; else increment p and go to WAIT_RDY.
- Entry ordering and pacing:
  - Entries go out in row-major order.
  - Consecutive sending_cpu pulses are separated by at least 1 cycle with fetch_ready re-observed high.
- LIST_END:
  - Wait for fetch_ready=1, then assert done_list for 1 cycle.
  - Go to SPIKE.
- SPIKE:
  - Wait 1 cycle, then assert sending_cpu=1 for 1 cycle with value={4'b0, spike}.
  - Go to COLLECT.
- COLLECT:
  - sending_out is registered as prev.
  - An event is any cycle where sending_out != prev. In that cycle output_val is captured to res_data.
  - res_idx = result counter; res_valid pulses 1 cycle later; the counter increments.
  - After 4 events, go to FINISH.
  - Further toggles are ignored until the next transaction.
- FINISH:
  - done=1 for 1 cycle, busy=0.
  - Go to IDLE.
- Timeout:
  - Applies in WAIT_RDY, LIST_END and COLLECT.
  - The counter resets on each state entry and on each COLLECT event.
  - When the counter reaches TIMEOUT_CYCLES: err=1, done pulse, return to IDLE.
  - No further accelerator strobes are issued.
- All-zero matrix:
  - No SEND occurs.
  - The sequence is START, WAIT_RDY, SCAN (16 cycles), LIST_END, SPIKE.
- Simultaneous events:
  - go while busy is ignored.
  - A toggle in the same cycle as COLLECT entry is counted.
- Reset mid-operation: all strobes drop to 0 asynchronously; the FSM is in IDLE.
- Output strobes (sending_cpu, done_list, acc_start) are registered, never combinational from inputs.
- Arithmetic: no arithmetic is performed on data; values pass through unchanged. The pointer is 4 bits and the result counter is 3 bits.

Decomposition:
- Shared package (mvm_pkg) holds:
  - N_DIM, VAL_W
  - FSM state encoding, shared naming with the accelerator's IDLE/COMPUTE/TRANSMIT/FETCH_CSR/FETCH_TRAIN
  - a csr_entry_t struct {row[1:0], col[1:0], val[7:0]}
- Sub-module csr_weight_ram: 16x8 register file with 1 write port and 1 asynchronous read port addressed by p.

Test Plan:
- Identity-like matrix (mem[0]=3, mem[5]=7, mem[10]=1, mem[15]=9), spike=4'b1111, fetch_ready held 1 -> exactly 4 sending_cpu pulses carrying (0,0,3), (1,1,7), (2,2,1), (3,3,9), separated by gaps; then done_list; then spike pulse with value=8'h0F.
- Accelerator model toggles sending_out 4 times with output_val 3, 7, 1, 9 -> res_valid ×4, res_idx 0..3, res_data 3, 7, 1, 9; done pulse; busy falls in the same cycle.
- All-zero matrix -> no entry pulses; done_list after the scan; spike pulse follows.
- fetch_ready held 0 after START with TIMEOUT_CYCLES=20 -> err=1 and done within 21 cycles; no sending_cpu ever asserted.
- rst_n pulled low mid-SEND sequence, after 2 of 4 entries -> all outputs 0 immediately. A new go restarts from entry (0,0,3).
- go asserted while busy, and mat_wr_en to an unscanned address mid-scan -> the go is ignored; the newly written non-zero value appears in the entry stream.

Source files
------------

// File: rtl/mvm_pkg.sv
// Definitions shared by the CSR stream feeder and the sparse MVM accelerator:
// matrix geometry, FSM state encodings and the CSR entry layout.
package mvm_pkg;

  localparam int N_DIM  = 4;
  localparam int VAL_W  = 8;
  localparam int ADDR_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SCAN,
    SEND,
    WAIT_RDY,
    LIST_END,
    SPIKE,
    COLLECT,
    FINISH
  } feeder_state_t;

  // Accelerator-side state names, kept here so both ends share one vocabulary.
  typedef enum logic [2:0] {
    ACC_IDLE,
    ACC_COMPUTE,
    ACC_TRANSMIT,
    ACC_FETCH_CSR,
    ACC_FETCH_TRAIN
  } acc_state_t;

  typedef struct packed {
    logic [1:0]       row;
    logic [1:0]       col;
    logic [VAL_W-1:0] val;
  } csr_entry_t;

  function automatic csr_entry_t make_entry(input logic [ADDR_W-1:0] addr,
                                            input logic [VAL_W-1:0]  val);
    make_entry = '{row: addr[3:2], col: addr[1:0], val: val};
  endfunction

endpackage

// File: rtl/csr_stream_feeder_if.sv
// Feeder <-> accelerator CSR load and result handshake.
// The feeder drives the master side; the accelerator drives the slave side.
interface csr_stream_feeder_if;
  import mvm_pkg::*;

  logic             acc_start;
  logic             sending_cpu;
  logic             done_list;
  logic [1:0]       row_val;
  logic [1:0]       column_val;
  logic [VAL_W-1:0] value;
  logic             fetch_ready;
  logic             sending_out;
  logic [VAL_W-1:0] output_val;

  modport master (
    output acc_start, sending_cpu, done_list, row_val, column_val, value,
    input  fetch_ready, sending_out, output_val
  );

  modport slave (
    input  acc_start, sending_cpu, done_list, row_val, column_val, value,
    output fetch_ready, sending_out, output_val
  );

endinterface

// File: rtl/csr_weight_ram.sv
// 16x8 dense weight store: one synchronous write port for the host and one
// asynchronous read port so the scan can test an address in the same cycle.
module csr_weight_ram
  import mvm_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [VAL_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [VAL_W-1:0]  rd_data
);

  logic [VAL_W-1:0] mem [N_DIM*N_DIM];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/csr_stream_feeder.sv
// Compresses the stored 4x4 matrix to CSR entries on the fly, streams them and
// the spike train to the accelerator, then collects its 4 toggle-signalled results.
module csr_stream_feeder
  import mvm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mat_wr_en,
  input  logic [ADDR_W-1:0]  mat_addr,
  input  logic [VAL_W-1:0]   mat_data,
  input  logic [N_DIM-1:0]   spike_in,
  input  logic               go,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               res_valid,
  output logic [1:0]         res_idx,
  output logic [VAL_W-1:0]   res_data,
  csr_stream_feeder_if.master acc
);

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] p_q, p_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              prev_q, prev_d;
  logic [N_DIM-1:0]  spike_q, spike_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic [1:0]        res_idx_q, res_idx_d;
  logic [VAL_W-1:0]  res_data_q, res_data_d;
  logic              acc_start_q, acc_start_d;
  logic              sending_cpu_q, sending_cpu_d;
  logic              done_list_q, done_list_d;
  csr_entry_t        entry_q, entry_d;
  logic [VAL_W-1:0]  mem_rd;
  logic [7:0]        tmo_inc;
  logic              tmo_expired;
  logic              toggle;

  csr_weight_ram u_ram (
    .clk     (clk),
    .wr_en   (mat_wr_en),
    .wr_addr (mat_addr),
    .wr_data (mat_data),
    .rd_addr (p_q),
    .rd_data (mem_rd)
  );

  assign tmo_inc     = tmo_q + 8'd1;
  assign tmo_expired = (tmo_inc == TMO_LIMIT);
  assign toggle      = (acc.sending_out != prev_q);

  always_comb begin
    state_d       = state_q;
    p_d           = p_q;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    prev_d        = acc.sending_out;
    spike_d       = spike_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    res_valid_d   = 1'b0;
    res_idx_d     = res_idx_q;
    res_data_d    = res_data_q;
    acc_start_d   = 1'b0;
    sending_cpu_d = 1'b0;
    done_list_d   = 1'b0;
    entry_d       = '0;

    case (state_q)
      IDLE: begin
        if (go) begin
          spike_d     = spike_in;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          acc_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = START;
        end
      end
      START: begin
        p_d     = '0;
        tmo_d   = '0;
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (acc.fetch_ready) begin
          state_d = SCAN;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      SCAN: begin
        if (mem_rd != '0) begin
          sending_cpu_d = 1'b1;
          entry_d       = make_entry(p_q, mem_rd);
          state_d       = SEND;
        end else if (p_q == 4'd15) begin
          tmo_d   = '0;
          state_d = LIST_END;
        end else begin
          p_d = p_q + 4'd1;
        end
      end
      SEND: begin
        tmo_d = '0;
        if (p_q == 4'd15) begin
          state_d = LIST_END;
        end else begin
          p_d     = p_q + 4'd1;
          state_d = WAIT_RDY;
        end
      end
      LIST_END: begin
        if (acc.fetch_ready) begin
          done_list_d = 1'b1;
          tmo_d       = '0;
          state_d     = SPIKE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      SPIKE: begin
        // tmo_q doubles as the one-cycle gap marker after done_list.
        if (tmo_q == 8'd0) begin
          tmo_d = 8'd1;
        end else begin
          sending_cpu_d = 1'b1;
          entry_d.val   = {{(VAL_W-N_DIM){1'b0}}, spike_q};
          tmo_d         = '0;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (toggle) begin
          res_valid_d = 1'b1;
          res_idx_d   = cnt_q[1:0];
          res_data_d  = acc.output_val;
          cnt_d       = cnt_q + 3'd1;
          tmo_d       = '0;
          if (cnt_q == 3'd3) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      p_q           <= '0;
      tmo_q         <= '0;
      cnt_q         <= '0;
      prev_q        <= 1'b0;
      spike_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      res_idx_q     <= '0;
      res_data_q    <= '0;
      acc_start_q   <= 1'b0;
      sending_cpu_q <= 1'b0;
      done_list_q   <= 1'b0;
      entry_q       <= '0;
    end else begin
      state_q       <= state_d;
      p_q           <= p_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      prev_q        <= prev_d;
      spike_q       <= spike_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      res_valid_q   <= res_valid_d;
      res_idx_q     <= res_idx_d;
      res_data_q    <= res_data_d;
      acc_start_q   <= acc_start_d;
      sending_cpu_q <= sending_cpu_d;
      done_list_q   <= done_list_d;
      entry_q       <= entry_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign res_valid       = res_valid_q;
  assign res_idx         = res_idx_q;
  assign res_data        = res_data_q;
  assign acc.acc_start   = acc_start_q;
  assign acc.sending_cpu = sending_cpu_q;
  assign acc.done_list   = done_list_q;
  assign acc.row_val     = entry_q.row;
  assign acc.column_val  = entry_q.col;
  assign acc.value       = entry_q.val;

endmodule

// File: tb/tb_csr_stream_feeder.sv
// Directed scoreboard bench for csr_stream_feeder: expected CSR strobes and
// results are queued as stimulus is driven and popped as the DUT emits them.
module tb_csr_stream_feeder;
  import mvm_pkg::*;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mat_wr_en;
  logic [3:0] mat_addr;
  logic [7:0] mat_data;
  logic [3:0] spike_in;
  logic       go;
  logic       busy, done, err, res_valid;
  logic [1:0] res_idx;
  logic [7:0] res_data;

  always #5 clk = ~clk;

  csr_stream_feeder_if acc_if ();

  csr_stream_feeder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mat_wr_en (mat_wr_en),
    .mat_addr  (mat_addr),
    .mat_data  (mat_data),
    .spike_in  (spike_in),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .res_valid (res_valid),
    .res_idx   (res_idx),
    .res_data  (res_data),
    .acc       (acc_if)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  tb_mem [16];
  logic [11:0] ent_q [$];
  logic [9:0]  res_q [$];
  int          cyc = 0;
  int          n_sc, n_dl, n_done, n_as, as_cyc, dl_cyc, done_cyc;
  bit          last_sc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [11:0] e;
    logic [9:0]  r;
    if (acc_if.sending_cpu) begin
      n_sc++;
      chk("sc_gap", 32'(last_sc), 32'd0);
      chk("sc_expected_pending", 32'(ent_q.size() != 0), 32'd1);
      if (ent_q.size() != 0) begin
        e = ent_q.pop_front();
        chk("csr_entry", 32'({acc_if.row_val, acc_if.column_val, acc_if.value}), 32'(e));
      end
    end
    last_sc = acc_if.sending_cpu;
    if (acc_if.done_list) begin
      n_dl++;
      dl_cyc = cyc;
      chk("dl_only_spike_left", 32'(ent_q.size()), 32'd1);
    end
    if (acc_if.acc_start) begin
      n_as++;
      as_cyc = cyc;
    end
    if (res_valid) begin
      chk("res_expected_pending", 32'(res_q.size() != 0), 32'd1);
      if (res_q.size() != 0) begin
        r = res_q.pop_front();
        chk("result", 32'({res_idx, res_data}), 32'(r));
      end
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      chk("busy_low_at_done", 32'(busy), 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic clr_counts();
    n_sc = 0; n_dl = 0; n_done = 0; n_as = 0;
    as_cyc = 0; dl_cyc = 0; done_cyc = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    mat_wr_en = 1'b1;
    mat_addr  = a;
    mat_data  = d;
    tb_mem[a] = d;
    cycle();
    mat_wr_en = 1'b0;
  endtask

  task automatic load_ident();
    for (int a = 0; a < 16; a++) begin
      wr(4'(a), (a == 0) ? 8'd3 : (a == 5) ? 8'd7 : (a == 10) ? 8'd1 : (a == 15) ? 8'd9 : 8'd0);
    end
  endtask

  task automatic push_entries(input logic [3:0] spk);
    for (int a = 0; a < 16; a++) begin
      if (tb_mem[a] != 8'd0) ent_q.push_back({4'(a), tb_mem[a]});
    end
    ent_q.push_back({4'h0, 4'h0, spk});
  endtask

  task automatic start_go(input logic [3:0] spk);
    spike_in = spk;
    go = 1'b1;
    cycle();
    go = 1'b0;
    chk("acc_start_after_go", 32'(acc_if.acc_start), 32'd1);
    chk("busy_after_go", 32'(busy), 32'd1);
    chk("err_clear_after_go", 32'(err), 32'd0);
  endtask

  task automatic wait_sent(input int budget);
    int k = 0;
    while (ent_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("all_entries_sent", 32'(ent_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      cycle();
      k++;
    end
    chk("done_seen", 32'(n_done != 0), 32'd1);
  endtask

  // Accelerator model: toggle sending_out once per result, 3 cycles apart.
  task automatic accel(input logic [31:0] vals);
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = vals[31 - 8*i -: 8];
      acc_if.output_val  = v;
      acc_if.sending_out = ~acc_if.sending_out;
      res_q.push_back({2'(i), v});
      cycle(); cycle(); cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mat_wr_en = 1'b0; mat_addr = '0; mat_data = '0;
    spike_in = '0; go = 1'b0;
    acc_if.fetch_ready = 1'b1;
    acc_if.sending_out = 1'b0;
    acc_if.output_val  = '0;
    clr_counts();

    // Reset state
    cycle(); cycle();
    chk("reset_status", 32'({busy, done, err, res_valid}), 32'd0);
    chk("reset_result", 32'({res_idx, res_data}), 32'd0);
    chk("reset_strobes", 32'({acc_if.acc_start, acc_if.sending_cpu, acc_if.done_list}), 32'd0);
    chk("reset_entry", 32'({acc_if.row_val, acc_if.column_val, acc_if.value}), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Identity-like matrix, full transaction
    load_ident();
    clr_counts();
    push_entries(4'hF);
    start_go(4'hF);
    wait_sent(200);
    accel(32'h03070109);
    wait_done(30);
    cycle(); cycle();
    chk("ident_sc_count", 32'(n_sc), 32'd5);
    chk("ident_dl_count", 32'(n_dl), 32'd1);
    chk("ident_as_count", 32'(n_as), 32'd1);
    chk("ident_done_count", 32'(n_done), 32'd1);
    chk("ident_err", 32'(err), 32'd0);
    chk("ident_res_drained", 32'(res_q.size()), 32'd0);

    // All-zero matrix: only done_list then the spike strobe
    for (int a = 0; a < 16; a++) wr(4'(a), 8'd0);
    clr_counts();
    push_entries(4'h5);
    start_go(4'h5);
    wait_sent(200);
    chk("zero_dl_latency", 32'(dl_cyc - as_cyc), 32'd19);
    chk("zero_sc_count", 32'(n_sc), 32'd1);
    accel(32'hA1B2C3D4);
    wait_done(30);
    chk("zero_err", 32'(err), 32'd0);

    // fetch_ready stuck low: timeout abort
    acc_if.fetch_ready = 1'b0;
    clr_counts();
    start_go(4'h3);
    wait_done(40);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_latency_le_21", 32'((done_cyc - as_cyc) <= 21), 32'd1);
    chk("tmo_no_sc", 32'(n_sc), 32'd0);
    chk("tmo_no_dl", 32'(n_dl), 32'd0);
    cycle(); cycle();
    chk("tmo_err_sticky", 32'(err), 32'd1);
    chk("tmo_idle", 32'(busy), 32'd0);
    acc_if.fetch_ready = 1'b1;

    // Asynchronous reset after 2 of 4 entries
    load_ident();
    clr_counts();
    push_entries(4'hF);
    start_go(4'hF);
    begin
      int k = 0;
      while (n_sc < 2 && k < 100) begin
        cycle();
        k++;
      end
    end
    chk("rst_two_sent", 32'(n_sc), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_status", 32'({busy, done, err, res_valid, res_idx}), 32'd0);
    chk("rst_async_strobes", 32'({acc_if.acc_start, acc_if.sending_cpu, acc_if.done_list, acc_if.value}), 32'd0);
    ent_q.delete();
    cycle();
    rst_n = 1'b1;
    cycle();
    clr_counts();
    push_entries(4'hF);
    start_go(4'hF);
    wait_sent(200);
    accel(32'h03070109);
    wait_done(30);
    chk("rst_restart_sc_count", 32'(n_sc), 32'd5);

    // go while busy is ignored; mid-scan write to an unscanned address is streamed
    clr_counts();
    tb_mem[14] = 8'h55;
    push_entries(4'hA);
    start_go(4'hA);
    go = 1'b1;
    wr(4'd14, 8'h55);
    go = 1'b0;
    cycle(); cycle();
    go = 1'b1;
    cycle();
    go = 1'b0;
    wait_sent(200);
    accel(32'h11223344);
    wait_done(30);
    cycle(); cycle();
    chk("busy_go_as_count", 32'(n_as), 32'd1);
    chk("midwrite_sc_count", 32'(n_sc), 32'd6);
    chk("busy_go_done_count", 32'(n_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
